// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath width, ALU/MDU operation codes and op-class helpers.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    SLL    = 5'd2,
    SLT    = 5'd3,
    SLTU   = 5'd4,
    XOR    = 5'd5,
    SRL    = 5'd6,
    SRA    = 5'd7,
    OR     = 5'd8,
    AND    = 5'd9,
    LUI    = 5'd10,
    AUIPC  = 5'd11,
    MUL    = 5'd12,
    MULH   = 5'd13,
    MULHSU = 5'd14,
    MULHU  = 5'd15,
    DIV    = 5'd16,
    DIVU   = 5'd17,
    REM    = 5'd18,
    REMU   = 5'd19
  } alu_op_t;

  function automatic logic is_mdu_op(input alu_op_t op);
    return op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_div_op(input alu_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M unit: shift-add multiplier and restoring divider on operand
// magnitudes, one result bit per cycle, with the sign applied once at DONE.
module mdu_iter
  import riscv_pkg::*;
#(
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter int MDU_ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (MDU_ITERS > 1) ? $clog2(MDU_ITERS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  alu_op_t         op_q;
  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            neg_res;
  logic            b_zero;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_q;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;
  logic [XLEN-1:0] div_hi;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // Operand decode at the start cycle: which operands are two's complement.
  always_comb begin
    a_sgn = op inside {MULH, MULHSU, DIV, REM};
    b_sgn = op inside {MULH, DIV, REM};
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration of each datapath; the FSM picks which one commits.
  always_comb begin
    div_q     = is_div_op(op_q);
    mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? mag_a : {XLEN{1'b0}})};
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, mag_b};
    div_sub   = XLEN'(div_shift - {1'b0, mag_b});
    div_hi    = div_ge ? div_sub : div_shift[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= ADD;
      a_raw   <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      hi      <= '0;
      lo      <= '0;
      neg_res <= 1'b0;
      b_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= BUSY;
            cnt     <= '0;
            op_q    <= op;
            a_raw   <= a;
            mag_a   <= a_mag;
            mag_b   <= b_mag;
            hi      <= '0;
            lo      <= is_div_op(op) ? a_mag : b_mag;
            neg_res <= (op == REM) ? a_neg : (a_neg ^ b_neg);
            b_zero  <= (b == '0);
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (div_q) begin
            hi <= div_hi;
            lo <= {lo[XLEN-2:0], div_ge};
          end else begin
            {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
          end
          if (cnt == CW'(MDU_ITERS - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sign fix-up; divide-by-zero overrides because the magnitude path
  // would otherwise negate the all-ones quotient.
  always_comb begin
    prod_fix = neg_res ? -{hi, lo} : {hi, lo};
    quo_fix  = neg_res ? -lo : lo;
    rem_fix  = neg_res ? -hi : hi;
    case (op_q)
      MUL:                 result = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: result = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           result = b_zero ? {XLEN{1'b1}} : quo_fix;
      REM, REMU:           result = b_zero ? a_raw : rem_fix;
      default:             result = '0;
    endcase
  end

  assign stall = ((state == IDLE) && start) || (state == BUSY);
  assign done  = (state == DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding from EX/MEM and MEM/WB, single-cycle ALU,
// and an iterative multiply/divide unit that stalls the front of the pipe.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter int MDU_ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWrite_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic            MemToReg_in,
  input  logic            ALUSrc_in,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  alu_op_t         alu_op,
  input  logic            exmem_RegWrite,
  input  logic            memwb_RegWrite,
  input  logic [4:0]      exmem_rd,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [XLEN-1:0] memwb_wdata,
  output logic            ex_stall,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            RegWrite_out,
  output logic            MemRead_out,
  output logic            MemWrite_out,
  output logic            MemToReg_out
);

  logic [4:0]      rs_idx [2];
  logic [XLEN-1:0] rs_val [2];
  logic [XLEN-1:0] fwd    [2];
  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_comb;
  logic [XLEN-1:0] mdu_result;
  logic            mdu_stall, mdu_done;

  assign rs_idx[0] = rs1;
  assign rs_idx[1] = rs2;
  assign rs_val[0] = rs1_data;
  assign rs_val[1] = rs2_data;

  // EX/MEM is the younger producer, so it wins; x0 is never forwarded.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd[gi] =
      (exmem_RegWrite && (exmem_rd != 5'd0) && (exmem_rd == rs_idx[gi])) ? exmem_result :
      (memwb_RegWrite && (memwb_rd != 5'd0) && (memwb_rd == rs_idx[gi])) ? memwb_wdata  :
      rs_val[gi];
  end

  assign op_a       = fwd[0];
  assign op_b       = ALUSrc_in ? imm : fwd[1];
  assign shamt      = op_b[4:0];
  assign store_data = fwd[1];

  always_comb begin
    case (alu_op)
      ADD:     alu_comb = op_a + op_b;
      SUB:     alu_comb = op_a - op_b;
      SLL:     alu_comb = op_a << shamt;
      SLT:     alu_comb = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      SLTU:    alu_comb = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      XOR:     alu_comb = op_a ^ op_b;
      SRL:     alu_comb = op_a >> shamt;
      SRA:     alu_comb = $signed(op_a) >>> shamt;
      OR:      alu_comb = op_a | op_b;
      AND:     alu_comb = op_a & op_b;
      LUI:     alu_comb = op_b;
      AUIPC:   alu_comb = pc + imm;
      default: alu_comb = '0;
    endcase
  end

  mdu_iter #(
    .XLEN      (XLEN),
    .MDU_ITERS (MDU_ITERS)
  ) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (is_mdu_op(alu_op)),
    .op     (alu_op),
    .a      (op_a),
    .b      (op_b),
    .stall  (mdu_stall),
    .done   (mdu_done),
    .result (mdu_result)
  );

  // While the MDU holds the pipe, EX/MEM receives bubbles.
  assign ex_stall     = mdu_stall;
  assign alu_result   = mdu_done ? mdu_result : alu_comb;
  assign rd_out       = rd;
  assign RegWrite_out = RegWrite_in & ~mdu_stall;
  assign MemRead_out  = MemRead_in  & ~mdu_stall;
  assign MemWrite_out = MemWrite_in & ~mdu_stall;
  assign MemToReg_out = MemToReg_in & ~mdu_stall;

endmodule
